// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI4-Stream packet generator with counter payload; define AXIS_PKT_GEN_GAP_EN to enable inter-packet gaps
module axis_pkt_gen #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int LEN_WIDTH       = 16,
    parameter int GAP_WIDTH       = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic [LEN_WIDTH-1:0]         pkt_len_i,
    input  logic [LEN_WIDTH-1:0]         pkt_num_i,
    input  logic [GAP_WIDTH-1:0]         gap_i,
    output logic                         busy_o,
    output logic [LEN_WIDTH-1:0]         pkt_cnt_o,
    output logic                         m_axis_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready
);
`ifdef AXIS_PKT_GEN_GAP_EN
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif
    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, num_q, num_d, pos_q, pos_d, cnt_q, cnt_d;
    logic [31:0]          beat_q, beat_d;
    logic                 stop_q, stop_d;
    logic                 xfer, last_beat, done;
    logic [LEN_WIDTH-1:0] cnt_inc;
`ifdef AXIS_PKT_GEN_GAP_EN
    logic [GAP_WIDTH-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
`else
    logic                 unused_gap;
    assign unused_gap = ^gap_i;
`endif
    assign xfer      = m_axis_tvalid && m_axis_tready;
    assign last_beat = pos_q == len_q - LEN_WIDTH'(1);
    assign cnt_inc   = cnt_q + LEN_WIDTH'(1);
    assign done      = (num_q != '0 && cnt_inc == num_q) || stop_i || stop_q;
    assign busy_o        = state_q != IDLE;
    assign pkt_cnt_o     = cnt_q;
    assign m_axis_tvalid = state_q == SEND;
    assign m_axis_tdata  = AXIS_DATA_WIDTH'(beat_q);
    assign m_axis_tstrb  = {(AXIS_DATA_WIDTH/8){m_axis_tvalid}};
    assign m_axis_tlast  = m_axis_tvalid && last_beat;

    // Next state: start capture, beat/packet counting, stop latch and gap countdown
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        num_d   = num_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        stop_d  = stop_q;
`ifdef AXIS_PKT_GEN_GAP_EN
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
`endif
        case (state_q)
            IDLE: if (start_i && pkt_len_i != '0) begin
                state_d = SEND;
                len_d   = pkt_len_i;
                num_d   = pkt_num_i;
                pos_d   = '0;
                cnt_d   = '0;
                beat_d  = '0;
                stop_d  = 1'b0;
`ifdef AXIS_PKT_GEN_GAP_EN
                gap_d   = gap_i;
`endif
            end
            SEND: begin
                stop_d = stop_q | stop_i;
                if (xfer) begin
                    beat_d = beat_q + 32'd1;
                    pos_d  = last_beat ? '0 : pos_q + LEN_WIDTH'(1);
                    if (last_beat) begin
                        cnt_d = cnt_inc;
`ifdef AXIS_PKT_GEN_GAP_EN
                        gcnt_d  = gap_q;
                        state_d = done ? IDLE : (gap_q != '0 ? GAP : SEND);
`else
                        state_d = done ? IDLE : SEND;
`endif
                    end
                end
            end
`ifdef AXIS_PKT_GEN_GAP_EN
            GAP: begin
                stop_d  = stop_q | stop_i;
                gcnt_d  = gcnt_q - GAP_WIDTH'(1);
                state_d = (stop_q || stop_i) ? IDLE : (gcnt_q == GAP_WIDTH'(1) ? SEND : GAP);
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            num_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
            stop_q  <= 1'b0;
`ifdef AXIS_PKT_GEN_GAP_EN
            gap_q   <= '0;
            gcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            num_q   <= num_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            stop_q  <= stop_d;
`ifdef AXIS_PKT_GEN_GAP_EN
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
`endif
        end
    end
endmodule
